// File: rtl/risc16_ctrl_if.sv
// Control bundle between the RiSC-16 sequencer and its datapath.
// master: the controller (drives strobes/selects, samples ir, eq_flag, mem_ready).
// slave : the datapath/memory side.
interface risc16_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic [15:0]      ir;
  logic             eq_flag;
  logic             mem_ready;
  logic             ir_ld;
  logic             pc_inc;
  logic             pc_ld;
  logic             pc_src;
  logic [2:0]       rf_ra1;
  logic [2:0]       rf_ra2;
  logic             rf_we;
  logic [2:0]       rf_wa;
  logic             wb_sel;
  logic [1:0]       src1_sel;
  logic             src2_sel;
  logic             alu_add;
  logic             alu_nand;
  logic             alu_pass1;
  logic             alu_eq;
  logic             res_ld;
  logic             mdr_ld;
  logic             mem_req;
  logic             mem_we;
  logic             addr_sel;
  logic             retire;
  logic [CNT_W-1:0] retired_cnt;
  logic             halted;
  logic             err;

  modport master (
    input  ir, eq_flag, mem_ready,
    output ir_ld, pc_inc, pc_ld, pc_src, rf_ra1, rf_ra2, rf_we, rf_wa, wb_sel,
           src1_sel, src2_sel, alu_add, alu_nand, alu_pass1, alu_eq, res_ld, mdr_ld,
           mem_req, mem_we, addr_sel, retire, retired_cnt, halted, err
  );

  modport slave (
    output ir, eq_flag, mem_ready,
    input  ir_ld, pc_inc, pc_ld, pc_src, rf_ra1, rf_ra2, rf_we, rf_wa, wb_sel,
           src1_sel, src2_sel, alu_add, alu_nand, alu_pass1, alu_eq, res_ld, mdr_ld,
           mem_req, mem_we, addr_sel, retire, retired_cnt, halted, err
  );
endinterface

// File: rtl/risc16_ctrl.sv
// Multi-cycle control FSM for the RiSC-16 core.
// Sequences FETCH/DECODE/EXEC/MEM/WB, decodes ir into datapath selects and one-hot ALU
// controls, handshakes the memory port with a timeout, and counts retired instructions.
// Ports: clk, rst (async, active-high), ctrl_io (master side of risc16_ctrl_if).
// All ctrl_io outputs are a combinational decode of the state register and ir.
module risc16_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255,  // 0 disables the memory timeout
  parameter int unsigned CNT_W       = 32
) (
  input logic           clk,
  input logic           rst,
  risc16_ctrl_if.master ctrl_io
);

  // Counter only needs to hold 0..MEM_TIMEOUT-1 before the limit fires.
  localparam int unsigned ToW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);

  typedef enum logic [2:0] {
    StIdle, StFetch, StDecode, StExec, StMem, StWb, StHalt, StError
  } state_e;

  typedef enum logic [2:0] {
    OpAdd = 3'd0, OpAddi = 3'd1, OpNand = 3'd2, OpLui = 3'd3,
    OpSw  = 3'd4, OpLw   = 3'd5, OpBeq  = 3'd6, OpJalr = 3'd7
  } opcode_e;

  state_e           state_q, state_d;
  logic [ToW-1:0]   to_cnt_q, to_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  opcode_e    op;
  logic [2:0] f_ra, f_rb, f_rc;
  logic       is_halt;
  logic       to_hit;
  logic       retire;

  assign op      = opcode_e'(ctrl_io.ir[15:13]);
  assign f_ra    = ctrl_io.ir[12:10];
  assign f_rb    = ctrl_io.ir[9:7];
  assign f_rc    = ctrl_io.ir[2:0];
  // JALR r0,r0 with a non-zero immediate is the halt encoding.
  assign is_halt = (op == OpJalr) && (f_ra == 3'd0) && (f_rb == 3'd0) &&
                   (ctrl_io.ir[6:0] != 7'd0);
  assign to_hit  = (MEM_TIMEOUT != 0) && (to_cnt_q == ToW'(MEM_TIMEOUT - 1));

  assign ctrl_io.retired_cnt = cnt_q;
  assign ctrl_io.retire      = retire;
  assign cnt_d               = cnt_q + CNT_W'(retire);

  always_comb begin
    state_d   = state_q;
    to_cnt_d  = '0;
    retire    = 1'b0;
    ctrl_io.ir_ld     = 1'b0;
    ctrl_io.pc_inc    = 1'b0;
    ctrl_io.pc_ld     = 1'b0;
    ctrl_io.pc_src    = 1'b0;
    ctrl_io.rf_ra1    = 3'd0;
    ctrl_io.rf_ra2    = 3'd0;
    ctrl_io.rf_we     = 1'b0;
    ctrl_io.rf_wa     = 3'd0;
    ctrl_io.wb_sel    = 1'b0;
    ctrl_io.src1_sel  = 2'd0;
    ctrl_io.src2_sel  = 1'b0;
    ctrl_io.alu_add   = 1'b0;
    ctrl_io.alu_nand  = 1'b0;
    ctrl_io.alu_pass1 = 1'b0;
    ctrl_io.alu_eq    = 1'b0;
    ctrl_io.res_ld    = 1'b0;
    ctrl_io.mdr_ld    = 1'b0;
    ctrl_io.mem_req   = 1'b0;
    ctrl_io.mem_we    = 1'b0;
    ctrl_io.addr_sel  = 1'b0;
    ctrl_io.halted    = 1'b0;
    ctrl_io.err       = 1'b0;

    // Read addresses are set up in DECODE and held until the instruction completes.
    if (state_q inside {StDecode, StExec, StMem, StWb}) begin
      case (op)
        OpAdd, OpNand:        begin ctrl_io.rf_ra1 = f_rb; ctrl_io.rf_ra2 = f_rc; end
        OpAddi, OpLw, OpJalr: ctrl_io.rf_ra1 = f_rb;
        OpSw:                 begin ctrl_io.rf_ra1 = f_rb; ctrl_io.rf_ra2 = f_ra; end
        OpBeq:                begin ctrl_io.rf_ra1 = f_ra; ctrl_io.rf_ra2 = f_rb; end
        default: ;
      endcase
    end

    unique case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        ctrl_io.mem_req = 1'b1;
        if (ctrl_io.mem_ready) begin
          ctrl_io.ir_ld  = 1'b1;
          ctrl_io.pc_inc = 1'b1;
          state_d        = StDecode;
        end else if (to_hit) begin
          state_d = StError;
        end else begin
          to_cnt_d = to_cnt_q + ToW'(1);
        end
      end
      StDecode: begin
        if (is_halt) begin
          retire  = 1'b1;
          state_d = StHalt;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        ctrl_io.res_ld = (op != OpBeq);
        state_d        = StWb;
        case (op)
          OpAdd:              ctrl_io.alu_add = 1'b1;
          OpAddi, OpLw, OpSw: begin
            ctrl_io.alu_add  = 1'b1;
            ctrl_io.src2_sel = 1'b1;
            if (op != OpAddi) state_d = StMem;
          end
          OpNand:             ctrl_io.alu_nand = 1'b1;
          OpLui: begin
            ctrl_io.alu_pass1 = 1'b1;
            ctrl_io.src1_sel  = 2'd2;
          end
          OpJalr: begin
            // Link value is the PC already incremented during FETCH.
            ctrl_io.alu_pass1 = 1'b1;
            ctrl_io.src1_sel  = 2'd1;
            ctrl_io.pc_ld     = 1'b1;
            ctrl_io.pc_src    = 1'b1;
          end
          default: begin  // OpBeq
            ctrl_io.alu_eq = 1'b1;
            ctrl_io.pc_ld  = ctrl_io.eq_flag;
            retire         = 1'b1;
            state_d        = StFetch;
          end
        endcase
      end
      StMem: begin
        ctrl_io.mem_req  = 1'b1;
        ctrl_io.addr_sel = 1'b1;
        ctrl_io.mem_we   = (op == OpSw);
        if (ctrl_io.mem_ready) begin
          if (op == OpSw) begin
            retire  = 1'b1;
            state_d = StFetch;
          end else begin
            ctrl_io.mdr_ld = 1'b1;
            state_d        = StWb;
          end
        end else if (to_hit) begin
          state_d = StError;
        end else begin
          to_cnt_d = to_cnt_q + ToW'(1);
        end
      end
      StWb: begin
        ctrl_io.rf_wa  = f_ra;
        ctrl_io.rf_we  = (f_ra != 3'd0);  // r0 is hardwired zero
        ctrl_io.wb_sel = (op == OpLw);
        retire         = 1'b1;
        state_d        = StFetch;
      end
      StHalt:  ctrl_io.halted = 1'b1;
      StError: ctrl_io.err    = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      to_cnt_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      to_cnt_q <= to_cnt_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_risc16_ctrl.sv
// Bench for risc16_ctrl: an instruction-level model emits the expected output vector for
// every cycle of each instruction; a single per-cycle compare checks the DUT against it.
module tb_risc16_ctrl;
  localparam int unsigned MTO = 4;
  localparam int HALT_N = 20;

  typedef struct packed {
    logic        ir_ld, pc_inc, pc_ld, pc_src;
    logic [2:0]  rf_ra1, rf_ra2;
    logic        rf_we;
    logic [2:0]  rf_wa;
    logic        wb_sel;
    logic [1:0]  src1_sel;
    logic        src2_sel;
    logic        alu_add, alu_nand, alu_pass1, alu_eq, res_ld, mdr_ld;
    logic        mem_req, mem_we, addr_sel, retire, halted, err;
    logic [31:0] retired_cnt;
  } outs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  risc16_ctrl_if #(.CNT_W(32)) bus ();

  risc16_ctrl #(.MEM_TIMEOUT(MTO), .CNT_W(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .ctrl_io(bus)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc_no = 0;
  logic [31:0] mcnt = '0;  // model retired count
  int dead = 0;            // 0 running, 1 halted, 2 error
  outs_t act;
  int t_cyc, t_req, t_we, t_wa, t_pcld, t_mdr, t_wbsel, t_memwe, t_add, t_halt, t_err;

  function automatic outs_t sample();
    outs_t o;
    o.ir_ld = bus.ir_ld;       o.pc_inc = bus.pc_inc;     o.pc_ld = bus.pc_ld;
    o.pc_src = bus.pc_src;     o.rf_ra1 = bus.rf_ra1;     o.rf_ra2 = bus.rf_ra2;
    o.rf_we = bus.rf_we;       o.rf_wa = bus.rf_wa;       o.wb_sel = bus.wb_sel;
    o.src1_sel = bus.src1_sel; o.src2_sel = bus.src2_sel; o.alu_add = bus.alu_add;
    o.alu_nand = bus.alu_nand; o.alu_pass1 = bus.alu_pass1; o.alu_eq = bus.alu_eq;
    o.res_ld = bus.res_ld;     o.mdr_ld = bus.mdr_ld;     o.mem_req = bus.mem_req;
    o.mem_we = bus.mem_we;     o.addr_sel = bus.addr_sel; o.retire = bus.retire;
    o.halted = bus.halted;     o.err = bus.err;           o.retired_cnt = bus.retired_cnt;
    return o;
  endfunction

  function automatic outs_t base();
    outs_t o = '0;
    o.retired_cnt = mcnt;
    return o;
  endfunction

  task automatic tz();
    t_cyc = 0; t_req = 0; t_we = 0; t_wa = -1; t_pcld = 0; t_mdr = 0;
    t_wbsel = 0; t_memwe = 0; t_add = 0; t_halt = 0; t_err = 0;
  endtask

  // The one per-cycle compare: drive inputs mid-cycle, sample 1ns later.
  task automatic cyc(input logic r, input logic [15:0] i, input logic e, input logic mr,
                     input outs_t x);
    @(negedge clk);
    rst = r; bus.ir = i; bus.eq_flag = e; bus.mem_ready = mr;
    #1;
    act = sample();
    n_chk++;
    if (act !== x) begin
      n_err++;
      $display("FAIL cyc%0d outputs: got %h want %h", cyc_no, act, x);
    end
    cyc_no++;
    t_cyc++;
    if (act.mem_req) t_req++;
    if (act.rf_we) begin t_we++; t_wa = int'(act.rf_wa); end
    if (act.pc_ld) t_pcld++;
    if (act.mdr_ld) t_mdr++;
    if (act.wb_sel) t_wbsel++;
    if (act.mem_we) t_memwe++;
    if (act.alu_add) t_add++;
    if (act.halted) t_halt++;
    if (act.err) t_err++;
  endtask

  task automatic lit(input string nm, input longint got, input longint want);
    n_chk++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic do_reset(input int n);
    outs_t x;
    mcnt = '0;
    dead = 0;
    x = base();
    for (int k = 0; k < n; k++) cyc(1'b1, 16'($urandom), 1'($urandom), 1'($urandom), x);
    cyc(1'b0, 16'($urandom), 1'($urandom), 1'($urandom), x);  // IDLE
  endtask

  task automatic go_error();
    outs_t x;
    dead = 2;
    x = base();
    x.err = 1'b1;
    for (int k = 0; k < 5; k++) cyc(1'b0, 16'($urandom), 1'($urandom), 1'($urandom), x);
  endtask

  // One instruction: wf/wm = cycles mem_ready stays low in FETCH/MEM.
  task automatic instr(input logic [15:0] i, input logic e, input int wf, input int wm,
                       input bit abort_mem);
    logic [2:0] op, ra, rb, rc, a1, a2;
    bit halt;
    outs_t x, h;
    op = i[15:13]; ra = i[12:10]; rb = i[9:7]; rc = i[2:0];
    halt = (op == 3'd7) && (ra == 3'd0) && (rb == 3'd0) && (i[6:0] != 7'd0);
    a1 = 3'd0; a2 = 3'd0;
    case (op)
      3'd0, 3'd2: begin a1 = rb; a2 = rc; end
      3'd1, 3'd5, 3'd7: a1 = rb;
      3'd4: begin a1 = rb; a2 = ra; end
      3'd6: begin a1 = ra; a2 = rb; end
      default: ;
    endcase
    for (int k = 1; k <= wf; k++) begin
      x = base(); x.mem_req = 1'b1;
      cyc(1'b0, 16'($urandom), 1'($urandom), 1'b0, x);
      if (MTO != 0 && k == int'(MTO)) begin go_error(); return; end
    end
    x = base(); x.mem_req = 1'b1; x.ir_ld = 1'b1; x.pc_inc = 1'b1;
    cyc(1'b0, 16'($urandom), 1'($urandom), 1'b1, x);
    h = base(); h.rf_ra1 = a1; h.rf_ra2 = a2;
    x = h; x.retire = halt;
    cyc(1'b0, i, 1'($urandom), 1'($urandom), x);
    if (halt) begin
      mcnt++;
      dead = 1;
      x = base(); x.halted = 1'b1;
      for (int k = 0; k < HALT_N; k++) cyc(1'b0, i, 1'($urandom), 1'($urandom), x);
      return;
    end
    x = h;
    x.res_ld = (op != 3'd6);
    case (op)
      3'd0: x.alu_add = 1'b1;
      3'd1, 3'd4, 3'd5: begin x.alu_add = 1'b1; x.src2_sel = 1'b1; end
      3'd2: x.alu_nand = 1'b1;
      3'd3: begin x.alu_pass1 = 1'b1; x.src1_sel = 2'd2; end
      3'd7: begin x.alu_pass1 = 1'b1; x.src1_sel = 2'd1; x.pc_ld = 1'b1; x.pc_src = 1'b1; end
      default: begin x.alu_eq = 1'b1; x.pc_ld = e; x.retire = 1'b1; end
    endcase
    cyc(1'b0, i, e, 1'($urandom), x);
    if (op == 3'd6) begin mcnt++; return; end
    if (op == 3'd4 || op == 3'd5) begin
      for (int k = 1; k <= wm; k++) begin
        x = h; x.mem_req = 1'b1; x.addr_sel = 1'b1; x.mem_we = (op == 3'd4);
        cyc(1'b0, i, 1'($urandom), 1'b0, x);
        if (abort_mem) return;
        if (MTO != 0 && k == int'(MTO)) begin go_error(); return; end
      end
      x = h; x.mem_req = 1'b1; x.addr_sel = 1'b1; x.mem_we = (op == 3'd4);
      x.retire = (op == 3'd4); x.mdr_ld = (op == 3'd5);
      cyc(1'b0, i, 1'($urandom), 1'b1, x);
      if (op == 3'd4) begin mcnt++; return; end
      h.retired_cnt = mcnt;
    end
    x = h; x.rf_wa = ra; x.rf_we = (ra != 3'd0); x.wb_sel = (op == 3'd5); x.retire = 1'b1;
    cyc(1'b0, i, 1'($urandom), 1'($urandom), x);
    mcnt++;
  endtask

  initial begin
    bus.ir = '0; bus.eq_flag = 1'b0; bus.mem_ready = 1'b0;
    tz();
    do_reset(3);

    // ADD r1,r2,r3
    tz();
    instr(16'h0503, 1'b0, 0, 0, 1'b0);
    lit("add_cycles", t_cyc, 4); lit("add_alu_add", t_add, 1);
    lit("add_rf_we", t_we, 1);   lit("add_rf_wa", t_wa, 1);
    lit("add_mem_req", t_req, 1);
    @(posedge clk); #1;
    lit("add_retired", bus.retired_cnt, 1);

    // BEQ r1,r2,+5 taken then not taken
    tz();
    instr(16'hC505, 1'b1, 0, 0, 1'b0);
    lit("beq_t_cycles", t_cyc, 3); lit("beq_t_pc_ld", t_pcld, 1);
    tz();
    instr(16'hC505, 1'b0, 0, 0, 1'b0);
    lit("beq_n_cycles", t_cyc, 3); lit("beq_n_pc_ld", t_pcld, 0); lit("beq_rf_we", t_we, 0);

    // LW r4,r2,-1 with 3 wait cycles in MEM
    tz();
    instr(16'hB17F, 1'b0, 0, 3, 1'b0);
    lit("lw_mem_req", t_req, 5);  lit("lw_mem_we", t_memwe, 0);
    lit("lw_mdr_ld", t_mdr, 1);   lit("lw_wb_sel", t_wbsel, 1);
    lit("lw_rf_wa", t_wa, 4);     lit("lw_cycles", t_cyc, 8);

    // ADD r0,r1,r2 then HALT
    do_reset(2);
    tz();
    instr(16'h0082, 1'b0, 0, 0, 1'b0);
    lit("r0_rf_we", t_we, 0);
    tz();
    instr(16'hE001, 1'b0, 0, 0, 1'b0);
    lit("halt_cycles", t_halt, HALT_N); lit("halt_mem_req", t_req, 1);
    lit("halt_retired", bus.retired_cnt, 2);

    // Timeout in FETCH, then ready on the last allowed wait cycle
    do_reset(2);
    tz();
    instr(16'h0503, 1'b0, 4, 0, 1'b0);
    lit("to_err", t_err, 5); lit("to_mem_req", t_req, 4);
    do_reset(2);
    tz();
    instr(16'h0503, 1'b0, 3, 0, 1'b0);
    lit("to_edge_err", t_err, 0); lit("to_edge_req", t_req, 4);
    @(posedge clk); #1;
    lit("to_edge_retired", bus.retired_cnt, 1);

    // Reset during MEM of SW r1,r2,3
    do_reset(2);
    tz();
    instr(16'h8503, 1'b0, 0, 3, 1'b1);
    lit("sw_mem_we_seen", t_memwe, 1);
    tz();
    do_reset(2);
    lit("sw_rst_mem_req", t_req, 0); lit("sw_rst_mem_we", t_memwe, 0);
    lit("sw_rst_retired", bus.retired_cnt, 0);
    instr(16'h0503, 1'b0, 1, 0, 1'b0);

    // Randomized instruction stream
    for (int n = 0; n < 300; n++) begin
      int wf, wm;
      if (dead != 0) do_reset(1 + ($urandom % 2));
      wf = ($urandom % 10 == 0) ? 4 : int'($urandom % 4);
      wm = ($urandom % 10 == 0) ? 4 : int'($urandom % 4);
      instr(16'($urandom), 1'($urandom), wf, wm, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/risc16_ctrl.md
Name: risc16_ctrl

Overview:
- Multi-cycle control FSM for the 16-bit RiSC-16 core.
- Decodes the instruction register and sequences the shared ALU, register file, PC and memory port over FETCH/DECODE/EXEC/MEM/WB.
- Drives the ALU one-hot controls (ADD, NAND, PASS1, EQ) and consumes the ALU equality flag.
- Sits between the instruction register and the datapath muxes.

Parameters:
- MEM_TIMEOUT, 255: cycles mem_req may stay unanswered before the ERROR state is entered; 0 disables the timeout.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- ir  in  16  instruction register contents; opcode [15:13], rA [12:10], rB [9:7], rC [2:0], simm7 [6:0], imm10 [9:0]
- eq_flag  in  1  ALU equality output
- mem_ready  in  1  memory accepts/completes the current request
- ir_ld  out  1  load IR from memory read data
- pc_inc  out  1  PC <= PC+1
- pc_ld  out  1  PC <= pc_src
- pc_src  out  1  0 = branch target (PC+simm7), 1 = register read port 1
- rf_ra1  out  3  register read address, port 1
- rf_ra2  out  3  register read address, port 2
- rf_we  out  1  register write enable
- rf_wa  out  3  register write address
- wb_sel  out  1  0 = result register, 1 = memory data register
- src1_sel  out  2  ALU operand 1: 0 = rd1, 1 = PC, 2 = imm10<<6
- src2_sel  out  1  ALU operand 2: 0 = rd2, 1 = sign-extended simm7
- alu_add  out  1  ALU ADD control
- alu_nand  out  1  ALU NAND control
- alu_pass1  out  1  ALU PASS1 control
- alu_eq  out  1  ALU EQ control
- res_ld  out  1  latch ALU output into the result register
- mdr_ld  out  1  latch memory read data into the MDR
- mem_req  out  1  memory request
- mem_we  out  1  memory write strobe
- addr_sel  out  1  memory address: 0 = PC, 1 = result register
- retire  out  1  one-cycle pulse per completed instruction
- retired_cnt  out  CNT_W  count of retired instructions
- halted  out  1  sticky, set in HALT
- err  out  1  sticky, set in ERROR

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, ERROR.
- Reset: state = IDLE; retired_cnt = 0; timeout counter = 0. Every output is 0 while rst is high and in IDLE. rst asserted mid-instruction aborts it immediately; no partial rf_we or mem_we is issued after rst rises.
- Outputs are a combinational decode of state and ir. ALU controls are one-hot or all-zero.
- IDLE: always moves to FETCH on the next cycle.
- FETCH: mem_req=1, addr_sel=0. Hold until mem_ready=1. In that cycle ir_ld=1 and pc_inc=1, then go to DECODE.
- DECODE: 1 cycle, drives rf_ra1/rf_ra2.
  - ADD, NAND: ra1=rB, ra2=rC.
  - ADDI, LW, JALR: ra1=rB.
  - SW: ra1=rB, ra2=rA.
  - BEQ: ra1=rA, ra2=rB.
  - rf_ra* hold these values through EXEC/MEM/WB.
  - JALR with rA=0, rB=0 and simm7!=0 is HALT: go to HALT and pulse retire.
- EXEC: 1 cycle, res_ld=1 except for BEQ.
  - ADD: alu_add, src2=0.
  - ADDI/LW/SW: alu_add, src2=1.
  - NAND: alu_nand.
  - LUI: alu_pass1, src1=2.
  - JALR: alu_pass1, src1=1 (link = already-incremented PC); pc_ld=1, pc_src=1.
  - BEQ: alu_eq. If eq_flag=1 then pc_ld=1, pc_src=0. Retire and go to FETCH.
  - Next state: LW/SW go to MEM; ADD/ADDI/NAND/LUI/JALR go to WB.
- MEM: mem_req=1, addr_sel=1, mem_we=1 for SW. Hold until mem_ready=1.
  - SW: retire, go to FETCH.
  - LW: mdr_ld=1, go to WB.
- WB: 1 cycle. rf_wa=rA. rf_we=1 unless rA=0 (r0 writes suppressed; instruction still retires). wb_sel=1 for LW only. Retire, go to FETCH.
- Handshake: mem_req stays high until the cycle mem_ready is sampled high, then drops the next cycle. mem_ready while mem_req=0 is ignored.
- Timeout: counter clears on entry to FETCH/MEM and increments each waiting cycle. When count = MEM_TIMEOUT with no mem_ready, go to ERROR. mem_ready arriving on the same cycle the limit is reached wins, so no error is raised.
- HALT/ERROR: terminal until rst. All strobes are 0; halted or err = 1.
- retired_cnt increments on each retire and wraps modulo 2^CNT_W.

Test Plan:
- ADD r1,r2,r3 with mem_ready always 1 -> FETCH, DECODE, EXEC, WB in 4 cycles; alu_add high in EXEC; rf_we=1, rf_wa=1 in WB; retired_cnt=1.
- BEQ r1,r2,+5 with eq_flag=1, then eq_flag=0 -> pc_ld=1/pc_src=0 in EXEC for the first, no pc_ld for the second; both take 3 cycles; no rf_we.
- LW r4,r2,-1 with mem_ready delayed 3 cycles in MEM -> mem_req high 4 cycles, mem_we=0, mdr_ld pulse, WB with wb_sel=1, rf_wa=4.
- ADD r0,r1,r2 then 16'hE001 (HALT) -> first retires with rf_we=0; HALT sets halted=1; mem_req stays 0 for 20 cycles; retired_cnt=2.
- MEM_TIMEOUT=4 with mem_ready stuck 0 in FETCH -> ERROR after 4 wait cycles, err=1; rerun with mem_ready on the 4th wait cycle -> no error.
- Assert rst during MEM of SW -> mem_req and mem_we drop immediately; after release, IDLE then FETCH; retired_cnt=0.
